// File: rtl/mem_bus_master.sv
// mem_bus_master: single-outstanding RAM access master with address range check.
// Accepts one request in IDLE and returns one registered completion pulse per access.
module mem_bus_master #(
    parameter int ADDR_LIMIT   = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        ram_bus_mode,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_write_data,
    input  logic [15:0] ram_read_data,
    output logic [15:0] access_count
);

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;

    localparam int              CW    = $clog2(READ_LATENCY + 2);
    localparam logic [CW-1:0]   LAT   = CW'(READ_LATENCY);
    localparam logic [CW-1:0]   ONE   = CW'(1);
    localparam logic [16:0]     LIMIT = 17'(ADDR_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          fault_q, fault_d;
    logic          mode_q, mode_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   count_q, count_d;

    logic accept;
    logic oor;

    assign accept = req_valid && ready_q;
    assign oor    = {1'b0, req_addr} >= LIMIT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 16'h0000;
                    fault_d = oor;
                    cnt_d   = '0;
                    if (oor) begin
                        state_d = RESP;
                    end else if (req_write) begin
                        state_d = WR;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // cnt_q counts edges since acceptance, minus one
                if (cnt_q == LAT) begin
                    rdata_d = ram_read_data;
                    count_d = count_q + 16'd1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            WR: begin
                count_d = count_q + 16'd1;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        valid_d = (state_d == RESP);
        mode_d  = (state_d == WR) ? MODE_WRITE : MODE_READ;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            mode_q  <= MODE_READ;
            rdata_q <= 16'h0000;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            mode_q  <= mode_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
        end
    end

    assign req_ready      = ready_q;
    assign rsp_valid      = valid_q;
    assign rsp_fault      = fault_q;
    assign rsp_rdata      = rdata_q;
    assign ram_bus_mode   = mode_q;
    assign ram_addr       = addr_q;
    assign ram_write_data = wdata_q;
    assign access_count   = count_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed table, corner sequences and random traffic
// against a transaction-level model of the RAM master.
module tb_mem_bus_master;

    localparam int   AL  = 1024;
    localparam int   RL  = 1;
    localparam logic MW  = 1'b1;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_fault;
    logic        ram_bus_mode;
    logic [15:0] ram_addr;
    logic [15:0] ram_write_data;
    logic [15:0] ram_read_data;
    logic [15:0] access_count;

    int checks = 0;
    int errors = 0;

    mem_bus_master #(
        .ADDR_LIMIT  (AL),
        .READ_LATENCY(RL)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_fault     (rsp_fault),
        .ram_bus_mode  (ram_bus_mode),
        .ram_addr      (ram_addr),
        .ram_write_data(ram_write_data),
        .ram_read_data (ram_read_data),
        .access_count  (access_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: synchronous write, read data RL edges after address sample
    logic [15:0] ram   [0:AL-1] = '{default: 16'h0000};
    logic [15:0] rpipe [0:RL-1] = '{default: 16'h0000};
    assign ram_read_data = rpipe[RL-1];

    always @(posedge clk) begin
        if (ram_bus_mode == MW) ram[ram_addr[9:0]] <= ram_write_data;
        rpipe[0] <= ram[ram_addr[9:0]];
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end

    // transaction-level reference
    logic [15:0] ref_mem [0:AL-1] = '{default: 16'h0000};
    logic [15:0] ref_cnt = 16'h0000;

    task automatic model(input logic wr, input logic [15:0] a,
                         input logic [15:0] wd, output logic f,
                         output logic [15:0] rd, output int lat,
                         output int strb, output logic [15:0] cnt);
        f    = (int'(a) >= AL);
        rd   = 16'h0000;
        strb = 0;
        lat  = 0;
        if (!f) begin
            if (wr) begin
                lat  = 1;
                strb = 1;
                ref_mem[int'(a)] = wd;
            end else begin
                lat = RL + 1;
                rd  = ref_mem[int'(a)];
            end
            ref_cnt = ref_cnt + 16'd1;
        end
        cnt = ref_cnt;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rvalid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_fault"}, 32'(rsp_fault), 32'd0);
        chk({tag, "_rdata"}, 32'(rsp_rdata), 32'd0);
        chk({tag, "_raddr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_rwdata"}, 32'(ram_write_data), 32'd0);
        chk({tag, "_mode"}, 32'(ram_bus_mode), 32'd0);
        chk({tag, "_count"}, 32'(access_count), 32'd0);
    endtask

    // drive one request, follow it to completion; called mid-cycle
    task automatic access(input logic wr, input logic [15:0] a,
                          input logic [15:0] wd, input logic hold,
                          input logic ef, input logic [15:0] erd,
                          input int elat, input int estr,
                          input logic [15:0] ecnt, input string tag);
        int   w;
        int   lat;
        int   strb;
        logic got;
        logic busy_ready;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk({tag, "_accept"}, 32'(w < 20), 32'd1);
        @(posedge clk);
        #1;
        req_valid = hold;
        req_write = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        got        = 1'b0;
        lat        = -1;
        strb       = 0;
        busy_ready = 1'b0;
        for (int n = 0; n < 12 && !got; n++) begin
            @(negedge clk);
            if (n == 0) begin
                chk({tag, "_ram_addr"}, 32'(ram_addr), 32'(a));
                chk({tag, "_ram_wdata"}, 32'(ram_write_data), 32'(wd));
            end
            if (ram_bus_mode === MW) strb++;
            if (req_ready !== 1'b0) busy_ready = 1'b1;
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                lat = n;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_strobes"}, 32'(strb), 32'(estr));
        chk({tag, "_fault"}, 32'(rsp_fault), 32'(ef));
        chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(erd));
        chk({tag, "_count"}, 32'(access_count), 32'(ecnt));
        chk({tag, "_busy_ready"}, 32'(busy_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [15:0] wd;
        logic        ef;
        logic [15:0] erd;
        int          elat;
        int          estr;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic        mf;
        logic [15:0] mrd;
        logic [15:0] mcnt;
        logic        wr;
        logic        hold;
        logic        last_hold;
        logic [15:0] a;
        logic [15:0] wd;
        int          mlat;
        int          mstr;

        tbl[0] = '{1'b1, 16'h0003, 16'h00A5, 1'b0, 16'h0000, 1, 1, 16'd1};
        tbl[1] = '{1'b0, 16'h0003, 16'h0000, 1'b0, 16'h00A5, 2, 0, 16'd2};
        tbl[2] = '{1'b0, 16'h0400, 16'h0000, 1'b1, 16'h0000, 0, 0, 16'd2};
        tbl[3] = '{1'b1, 16'h03FF, 16'hBEEF, 1'b0, 16'h0000, 1, 1, 16'd3};
        tbl[4] = '{1'b1, 16'h0400, 16'h5555, 1'b1, 16'h0000, 0, 0, 16'd3};
        tbl[5] = '{1'b0, 16'h03FF, 16'h0000, 1'b0, 16'hBEEF, 2, 0, 16'd4};
        tbl[6] = '{1'b1, 16'hFFFF, 16'h1111, 1'b1, 16'h0000, 0, 0, 16'd4};
        tbl[7] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2, 0, 16'd5};

        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        resetn    = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        chk_rst("rst");
        @(posedge clk);
        @(negedge clk);
        chk_rst("rst_hold");
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            model(tbl[i].wr, tbl[i].a, tbl[i].wd, mf, mrd, mlat, mstr, mcnt);
            access(tbl[i].wr, tbl[i].a, tbl[i].wd, 1'b0, tbl[i].ef,
                   tbl[i].erd, tbl[i].elat, tbl[i].estr, tbl[i].ecnt,
                   $sformatf("tbl%0d", i));
        end

        // requester keeps req_valid high, alternating write/read
        for (int i = 0; i < 6; i++) begin
            wr = (i % 2 == 0);
            wd = 16'h1000 + 16'(i);
            model(wr, 16'h0010, wd, mf, mrd, mlat, mstr, mcnt);
            access(wr, 16'h0010, wd, 1'b1, mf, mrd, mlat, mstr, mcnt,
                   $sformatf("hold%0d", i));
        end
        req_valid = 1'b0;

        last_hold = 1'b0;
        for (int i = 0; i < 60; i++) begin
            wr   = 1'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                a = 16'($urandom_range(AL, 65535));
            else
                a = 16'($urandom_range(0, 31));
            wd = 16'($urandom);
            if (!last_hold) repeat ($urandom_range(0, 2)) @(negedge clk);
            model(wr, a, wd, mf, mrd, mlat, mstr, mcnt);
            access(wr, a, wd, hold, mf, mrd, mlat, mstr, mcnt,
                   $sformatf("rnd%0d", i));
            last_hold = hold;
        end
        req_valid = 1'b0;

        // reset during the write strobe cycle
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 16'h1234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rstwr_strobe", 32'(ram_bus_mode), 32'(MW));
        #1;
        resetn = 1'b0;
        #1;
        chk_rst("rstwr");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("rstwr_novalid%0d", i), 32'(rsp_valid), 32'd0);
        end
        resetn  = 1'b1;
        ref_cnt = 16'h0000;
        model(1'b0, 16'h0020, 16'h0000, mf, mrd, mlat, mstr, mcnt);
        access(1'b0, 16'h0020, 16'h0000, 1'b0, mf, mrd, mlat, mstr, mcnt,
               "post_rst");

        // counter wrap
        force dut.count_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.count_q;
        @(negedge clk);
        chk("wrap_preload", 32'(access_count), 32'h0000FFFF);
        ref_cnt = 16'hFFFF;
        model(1'b1, 16'h0005, 16'h7777, mf, mrd, mlat, mstr, mcnt);
        access(1'b1, 16'h0005, 16'h7777, 1'b0, mf, mrd, mlat, mstr, mcnt,
               "wrap");
        chk("wrap_zero", 32'(access_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter: ADDR_LIMIT, 1024, number of valid RAM word addresses; addresses >= ADDR_LIMIT fault.
REQ-002 Parameter: READ_LATENCY, 1, RAM clock cycles from address sample to valid read data (range 1-4).
REQ-003 clk  in  1  rising-edge system clock.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  requester presents an access.
REQ-006 req_ready  out  1  block accepts an access this cycle.
REQ-007 req_write  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  16  word address.
REQ-009 req_wdata  in  16  write data.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  16  read data; valid with rsp_valid.
REQ-012 rsp_fault  out  1  access was out of range; valid with rsp_valid.
REQ-013 ram_bus_mode  out  1  RAM write enable; MODE_WRITE from const.vh = write, otherwise read.
REQ-014 ram_addr  out  16  RAM address, registered.
REQ-015 ram_write_data  out  16  RAM write data, registered.
REQ-016 ram_read_data  in  16  RAM read data.
REQ-017 access_count  out  16  completed in-range accesses, wraps.

Function
REQ-018 The block SHALL implement states IDLE, RD_WAIT, WR, RESP; all outputs are registered.
REQ-019 req_ready SHALL be 1 only in IDLE; an access is accepted on the rising edge where req_valid && req_ready (edge E0).
REQ-020 At E0 the block SHALL register req_addr into ram_addr and req_wdata into ram_write_data; both hold until the next acceptance.
REQ-021 In-range read: E0 -> RD_WAIT; the block SHALL capture ram_read_data into rsp_rdata at edge E(READ_LATENCY+1) and move to RESP.
REQ-022 In-range write: E0 -> WR; ram_bus_mode SHALL equal MODE_WRITE for exactly the one cycle spent in WR; E1 -> RESP.
REQ-023 ram_bus_mode SHALL be the read value in every state other than WR.
REQ-024 Out-of-range access (req_addr >= ADDR_LIMIT): E0 -> RESP directly; no write strobe; rsp_fault=1, rsp_rdata=0; access_count unchanged.
REQ-025 In RESP, rsp_valid SHALL be 1 for exactly one cycle; the next edge returns to IDLE unconditionally (no response backpressure).
REQ-026 rsp_fault SHALL be 0 for in-range accesses; rsp_rdata SHALL be 0 for writes.
REQ-027 Latency SHALL be: read, rsp_valid high in the cycle after E(READ_LATENCY+1); write, after E1; fault, after E0.
REQ-028 Throughput: a new request SHALL not be accepted before the cycle following RESP; back-to-back requests are spaced by this rule.
REQ-029 access_count SHALL increment by 1 on entry to RESP for in-range accesses, wrapping 0xFFFF -> 0x0000.
REQ-030 req_* inputs SHALL be ignored outside the acceptance edge; changes while busy have no effect.
REQ-031 The RD_WAIT cycle counter SHALL be sized to hold READ_LATENCY+1 and reset to 0 on each acceptance.

Reset
REQ-032 While resetn=0: state IDLE, req_ready=1, rsp_valid=0, rsp_fault=0, rsp_rdata=0, ram_addr=0, ram_write_data=0, ram_bus_mode=read, access_count=0.
REQ-033 Reset asserted mid-access SHALL immediately force ram_bus_mode to read (no partial write strobe beyond the reset assertion) and abandon the access without rsp_valid.
REQ-034 After resetn deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-035 Write 0x00A5 to 0x0003 -> one WR cycle with ram_addr=0x0003, ram_write_data=0x00A5, mode=write; rsp_valid one cycle later, rsp_fault=0, access_count=1.
REQ-036 Read 0x0003 after REQ-035 write (RAM model, READ_LATENCY=1) -> rsp_valid after E2, rsp_rdata=0x00A5, mode read throughout.
REQ-037 Read 0x0400 (ADDR_LIMIT=1024) -> rsp_valid after E0, rsp_fault=1, rsp_rdata=0, no write strobe, access_count unchanged.
REQ-038 req_valid held high with alternating write/read at 0x0010 -> req_ready low while busy, each access completes once, access_count counts each completion.
REQ-039 resetn pulled low in WR cycle -> ram_bus_mode read immediately, no rsp_valid, all outputs at reset values; next request completes normally.
REQ-040 access_count preloaded to 0xFFFF via 65535 writes (or forced) then one more in-range access -> access_count=0x0000.
